// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word fetches, buffers returned words with
// their PCs for decode, and on redirect flushes the buffer and drops stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        fifo_q [DEPTH];

  logic [CW:0]   credit;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   target;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  entry_t        head;

  // Credit covers both in-flight requests and buffered words, so a push never overflows.
  always_comb begin
    credit           = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid_o = rst_ni && (credit < DEPTH_W);
    imem_req_addr_o  = fetch_pc;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    rsp_fire         = imem_rsp_valid_i && (outstanding != '0);
    push             = rsp_fire && !redirect_i && (drop_cnt == '0);
    instr_valid_o    = (count != '0);
    pop              = instr_valid_o && instr_ready_i;
    outstanding_nxt  = outstanding + CW'(req_fire) - CW'(rsp_fire);
    target           = redirect_pc_i & ~32'h0000_0003;
    head             = fifo_q[rd_ptr];
    instr_o          = instr_valid_o ? head.instr : NOP;
    pc_o             = instr_valid_o ? head.pc : 32'h0000_0000;
    pc_plus4_o       = pc_o + 32'd4;
  end

  // Redirect wins: everything still in flight at the end of the cycle becomes stale.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        drop_cnt <= outstanding_nxt;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_fire && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Buffer storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data_i};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model plus an in-order PC/word stream model checked
// every cycle, with directed scenarios pinning reset, latency, backpressure and redirect.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_ni;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o (imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i (imem_rsp_data_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         mem_q[$];
  ev_t         fire_log[$];
  ev_t         pop_log[$];
  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned cyc;
  int unsigned lat;
  int unsigned gaps;
  int unsigned ready_mode;
  int unsigned iready_mode;
  int unsigned r;
  bit          redir_req;
  bit          hold_pending;
  bit          count_gaps;
  bit          last_fire;
  bit          last_rsp;
  logic [31:0] redir_tgt;
  logic [31:0] exp_fetch;
  logic [31:0] exp_pc;

  // Memory contents: one fixed opcode at the reset PC, otherwise a bijection of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:2], 2'b11, a[31:16]};
  endfunction

  function automatic bit pick(input int unsigned mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: check outputs, drive inputs for the coming edge, advance the model.
  task automatic step();
    logic        rv, iv, rdy, irdy, rspv, red, fired, popped;
    logic [31:0] ra, io, pcv, pp4, rspd, tgt;
    ev_t         e;
    rv = imem_req_valid_o; ra = imem_req_addr_o;
    iv = instr_valid_o; io = instr_o; pcv = pc_o; pp4 = pc_plus4_o;
    if (iv) begin
      chk("pc", pcv, exp_pc);
      chk("instr", io, word(exp_pc));
      chk("pc_plus4", pp4, pcv + 32'd4);
    end else begin
      chk("empty_instr", io, NOP);
      chk("empty_pc", pcv, 32'h0);
      chk("empty_pc_plus4", pp4, 32'h4);
    end
    if (rv) begin
      chk("req_addr", ra, exp_fetch);
      chk("req_credit", 32'(mem_q.size() < DEPTH), 32'd1);
    end
    if (hold_pending) chk("req_hold", 32'(rv), 32'd1);
    if (count_gaps && !iv) gaps++;

    rdy = pick(ready_mode);
    irdy = pick(iready_mode);
    rspv = 1'b0;
    rspd = $urandom;
    if (mem_q.size() > 0 && mem_q[0].cyc <= cyc) begin
      rspv = 1'b1;
      rspd = word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    red = redir_req;
    tgt = redir_tgt;
    redir_req = 1'b0;

    fired = rv && rdy;
    if (fired) begin
      e.cyc = cyc + lat; e.addr = ra; e.data = 32'h0;
      mem_q.push_back(e);
      e.cyc = cyc;
      fire_log.push_back(e);
      exp_fetch = exp_fetch + 32'd4;
    end
    popped = iv && irdy;
    if (popped) begin
      e.cyc = cyc; e.addr = pcv; e.data = io;
      pop_log.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    if (red) begin
      exp_fetch = tgt & ~32'h3;
      exp_pc    = tgt & ~32'h3;
    end
    hold_pending = rv && !rdy && !red;
    last_fire = fired;
    last_rsp  = rspv;

    imem_req_ready_i = rdy;
    imem_rsp_valid_i = rspv;
    imem_rsp_data_i  = rspd;
    instr_ready_i    = irdy;
    redirect_i       = red;
    redirect_pc_i    = red ? tgt : $urandom;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'h0;
    instr_ready_i    = 1'b0;
    mem_q.delete();
    fire_log.delete();
    pop_log.delete();
    redir_req = 1'b0;
    hold_pending = 1'b0;
    exp_fetch = RESET_PC;
    exp_pc    = RESET_PC;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 32'h0);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid_o), 32'd1);
    chk("post_rst_req_addr", imem_req_addr_o, RESET_PC);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; lat = 1; gaps = 0;
    ready_mode = 1; iready_mode = 1; count_gaps = 1'b0; redir_tgt = 32'h0;

    // Reset release and streaming with a 1-cycle memory
    do_reset();
    lat = 1; ready_mode = 1; iready_mode = 1;
    repeat (3) step();
    gaps = 0; count_gaps = 1'b1;
    repeat (30) step();
    count_gaps = 1'b0;
    chk("first_addr0", fire_log[0].addr, 32'h100);
    chk("first_addr1", fire_log[1].addr, 32'h104);
    chk("first_addr2", fire_log[2].addr, 32'h108);
    chk("back_to_back", fire_log[2].cyc - fire_log[0].cyc, 32'd2);
    chk("first_valid_latency", pop_log[0].cyc - fire_log[0].cyc, 32'd2);
    chk("first_pc", pop_log[0].addr, 32'h100);
    chk("first_instr", pop_log[0].data, 32'h0050_0093);
    chk("stream_gaps", gaps, 32'd0);
    chk("stream_pops", pop_log.size(), 32'd31);

    // Decode backpressure: credits run out after DEPTH requests
    do_reset();
    lat = 1; ready_mode = 1; iready_mode = 0;
    repeat (10) step();
    chk("bp_fires", fire_log.size(), 32'd4);
    chk("bp_req_stopped", 32'(imem_req_valid_o), 32'd0);
    chk("bp_head_pc", pc_o, 32'h100);
    iready_mode = 1;
    repeat (12) step();
    chk("bp_resume_addr", fire_log[4].addr, 32'h110);
    for (int i = 0; i < 4; i++) chk("bp_drain_pc", pop_log[i].addr, 32'h100 + 32'(4 * i));

    // Redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3; ready_mode = 1; iready_mode = 1;
    step(); step();
    ready_mode = 0; redir_req = 1'b1; redir_tgt = 32'h203; r = cyc;
    step();
    fire_log.delete(); pop_log.delete();
    ready_mode = 1;
    repeat (10) step();
    chk("redir_addr", fire_log[0].addr, 32'h200);
    chk("redir_req_latency", fire_log[0].cyc - r, 32'd1);
    chk("redir_first_pc", pop_log[0].addr, 32'h200);
    chk("redir_first_instr", pop_log[0].data, word(32'h200));
    chk("redir_valid_latency", pop_log[0].cyc - r, 32'd5);

    // Redirect coinciding with a request fire and a response
    do_reset();
    lat = 1; ready_mode = 1; iready_mode = 1;
    repeat (5) step();
    redir_req = 1'b1; redir_tgt = 32'h400; r = cyc;
    step();
    chk("simul_fire", 32'(last_fire), 32'd1);
    chk("simul_rsp", 32'(last_rsp), 32'd1);
    fire_log.delete(); pop_log.delete();
    repeat (8) step();
    chk("simul_addr", fire_log[0].addr, 32'h400);
    chk("simul_req_latency", fire_log[0].cyc - r, 32'd1);
    chk("simul_first_pc", pop_log[0].addr, 32'h400);
    chk("simul_valid_latency", pop_log[0].cyc - r, 32'd3);

    // Randomized handshakes, latencies and redirects (including targets near wrap)
    do_reset();
    for (int s = 0; s < 8; s++) begin
      lat = $urandom_range(1, 4); ready_mode = 2; iready_mode = 2;
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 24) == 0) begin
          redir_req = 1'b1;
          redir_tgt = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0) | ($urandom & 32'hFFF);
        end
        step();
      end
    end
    chk("random_progress", 32'(pop_log.size() > 200), 32'd1);

    // Asynchronous reset with a full buffer
    do_reset();
    lat = 1; ready_mode = 1; iready_mode = 0;
    repeat (8) step();
    chk("full_before_reset", 32'(instr_valid_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_req_valid", 32'(imem_req_valid_o), 32'd0);
    chk("async_instr_valid", 32'(instr_valid_o), 32'd0);
    chk("async_instr", instr_o, NOP);
    chk("async_pc", pc_o, 32'h0);
    do_reset();
    iready_mode = 1;
    repeat (10) step();
    chk("restart_addr", fire_log[0].addr, RESET_PC);
    chk("restart_first_pc", pop_log[0].addr, RESET_PC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
